// File: rtl/multiphase_clock_gen_pkg.sv
// Shared types and sizing helpers for the multiphase clock generator.
package multiphase_clock_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } genState_e;

    localparam int MAX_PHASES = 8;

    // A single-bit slot register is still needed when PHASES is 2.
    function automatic int slot_width(input int phases);
        return (phases <= 2) ? 1 : $clog2(phases);
    endfunction

endpackage

// File: rtl/slot_counter.sv
// Cycle-within-slot counter with shadowed slot length and gap.
// inWindow/cntZero describe the cycle being entered so the top can register its decode.
module slot_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          count,
    input  logic          load,
    input  logic [CW-1:0] divIn,
    input  logic [CW-1:0] gapIn,
    output logic          slotEnd,
    output logic          inWindow,
    output logic          cntZero
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] divS;
    logic [CW-1:0] gapS;
    logic [CW-1:0] cntNext;
    logic [CW-1:0] divNext;
    logic [CW-1:0] gapNext;

    assign slotEnd = (cnt == divS);

    always_comb begin
        cntNext = '0;
        if (count && !slotEnd) begin
            cntNext = cnt + CW'(1);
        end
        divNext = load ? divIn : divS;
        gapNext = load ? gapIn : gapS;
    end

    // A gap larger than the slot keeps this low for the whole slot.
    assign inWindow = (cntNext >= gapNext);
    assign cntZero  = (cntNext == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            divS <= '0;
            gapS <= '0;
        end else begin
            cnt  <= cntNext;
            divS <= divNext;
            gapS <= gapNext;
        end
    end

endmodule

// File: rtl/multiphase_clock_gen.sv
// Generates PHASES non-overlapping phase strobes with programmable slot length and dead time.
// Outputs are decoded from next-state and registered, so nothing reaches them combinationally.
module multiphase_clock_gen
    import multiphase_clock_gen_pkg::*;
#(
    parameter int PHASES = 2,
    parameter int CW     = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [CW-1:0]     DIV,
    input  logic [CW-1:0]     GAP,
    output logic [PHASES-1:0] PH,
    output logic              SYNC,
    output logic              ACTIVE
);

    localparam int SW = slot_width(PHASES);
    localparam logic [SW-1:0] LAST_SLOT = SW'(PHASES - 1);

    if (PHASES < 2 || PHASES > MAX_PHASES) begin : gBadPhases
        $error("multiphase_clock_gen: PHASES must be 2..8");
    end

    genState_e         state;
    genState_e         stateNext;
    logic [SW-1:0]     slot;
    logic [SW-1:0]     slotNext;
    logic              slotEnd;
    logic              frameWrap;
    logic              count;
    logic              load;
    logic              inWindow;
    logic              cntZero;
    logic [PHASES-1:0] phNext;

    assign frameWrap = slotEnd && (slot == LAST_SLOT);

    slot_counter #(.CW(CW)) uSlotCounter (
        .clk      (CLK),
        .rst      (RST),
        .count    (count),
        .load     (load),
        .divIn    (DIV),
        .gapIn    (GAP),
        .slotEnd  (slotEnd),
        .inWindow (inWindow),
        .cntZero  (cntZero)
    );

    always_comb begin
        stateNext = state;
        slotNext  = slot;
        phNext    = '0;

        case (state)
            IDLE:    if (EN) stateNext = RUN;
            RUN:     if (!EN) stateNext = frameWrap ? IDLE : DRAIN;
            DRAIN: begin
                // Re-enabling resumes the current frame rather than restarting it.
                if (EN) stateNext = RUN;
                else if (frameWrap) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        count = (state != IDLE) && (stateNext != IDLE);
        load  = (stateNext == RUN) && ((state == IDLE) || frameWrap);

        if (!count) begin
            slotNext = '0;
        end else if (slotEnd) begin
            slotNext = frameWrap ? '0 : slot + SW'(1);
        end

        for (int k = 0; k < PHASES; k++) begin
            if ((stateNext != IDLE) && inWindow && (slotNext == SW'(k))) begin
                phNext[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            slot   <= '0;
            PH     <= '0;
            SYNC   <= 1'b0;
            ACTIVE <= 1'b0;
        end else begin
            state  <= stateNext;
            slot   <= slotNext;
            PH     <= phNext;
            SYNC   <= (stateNext != IDLE) && (slotNext == '0) && cntZero;
            ACTIVE <= (stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_multiphase_clock_gen.sv
// Directed-vector bench: a 4-phase instance driven from a table, a 2-phase instance by hand.
module tb_multiphase_clock_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, en4;
    logic [3:0] div4, gap4;
    logic [3:0] ph4;
    logic       sync4, active4;

    logic       rst2, en2;
    logic [3:0] div2, gap2;
    logic [1:0] ph2;
    logic       sync2, active2;

    multiphase_clock_gen #(.PHASES(4), .CW(4)) dut4 (
        .CLK(clk), .RST(rst4), .EN(en4), .DIV(div4), .GAP(gap4),
        .PH(ph4), .SYNC(sync4), .ACTIVE(active4)
    );

    multiphase_clock_gen #(.PHASES(2), .CW(4)) dut2 (
        .CLK(clk), .RST(rst2), .EN(en2), .DIV(div2), .GAP(gap2),
        .PH(ph2), .SYNC(sync2), .ACTIVE(active2)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] div;
        logic [3:0] gap;
        logic [3:0] ph;
        logic       sync;
        logic       active;
    } vec_t;

    vec_t vecs[$];
    int nVec = 0;
    int nErr = 0;

    task automatic addVec(input logic r, input logic e, input logic [3:0] d, input logic [3:0] g,
                          input logic [3:0] p, input logic s, input logic a);
        vec_t v;
        v.rst = r; v.en = e; v.div = d; v.gap = g;
        v.ph = p; v.sync = s; v.active = a;
        vecs.push_back(v);
    endtask

    // Expected outputs at frame cycle f of a 4-phase frame built with fDiv/fGap.
    task automatic addRun(input logic e, input int inDiv, input int inGap,
                          input int fDiv, input int fGap, input int f);
        int sl, c;
        logic [3:0] p;
        sl = f / (fDiv + 1);
        c  = f % (fDiv + 1);
        p  = '0;
        if (c >= fGap) p[sl] = 1'b1;
        addVec(1'b0, e, 4'(inDiv), 4'(inGap), p, (f == 0), 1'b1);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [3:0] gotPh, input logic gotS, input logic gotA,
                         input logic [3:0] expPh, input logic expS, input logic expA);
        nVec++;
        if (gotPh !== expPh || gotS !== expS || gotA !== expA) begin
            nErr++;
            $display("FAIL %s[%0d]: got PH=%b SYNC=%b ACTIVE=%b, expected PH=%b SYNC=%b ACTIVE=%b",
                     name, idx, gotPh, gotS, gotA, expPh, expS, expA);
        end
    endtask

    function automatic logic [1:0] legacyPh(input int f);
        logic [1:0] p;
        p = 2'b00;
        if (f == 1) p = 2'b01;
        if (f == 3) p = 2'b10;
        return p;
    endfunction

    initial begin
        rst4 = 1'b1; en4 = 1'b0; div4 = 4'd0; gap4 = 4'd0;
        rst2 = 1'b1; en2 = 1'b0; div2 = 4'd1; gap2 = 4'd1;

        // Reset, then idle with EN low.
        addVec(1'b1, 1'b0, 4'd0, 4'd0, 4'h0, 1'b0, 1'b0);
        addVec(1'b1, 1'b0, 4'd0, 4'd0, 4'h0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'd3, 4'd1, 4'h0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 4'd3, 4'd1, 4'h0, 1'b0, 1'b0);
        // Three 16-cycle frames, DIV=3 GAP=1.
        for (int k = 0; k < 48; k++) addRun(1'b1, 3, 1, 3, 1, k % 16);
        // DIV moves to 5 at frame cycle 6; this frame keeps 4-cycle slots.
        for (int f = 0; f < 16; f++) addRun(1'b1, (f >= 6) ? 5 : 3, 1, 3, 1, f);
        // 6-cycle slots; EN drops in slot 1 and the frame drains fully.
        for (int f = 0; f < 24; f++) addRun((f < 8), 5, 1, 5, 1, f);
        for (int k = 0; k < 3; k++) addVec(1'b0, 1'b0, 4'd5, 4'd1, 4'h0, 1'b0, 1'b0);
        // Gap longer than slot: no phase, SYNC every 16.
        for (int k = 0; k < 32; k++) addRun(1'b1, 3, 5, 3, 5, k % 16);
        // DIV=0 GAP=0: one-cycle pulses in turn.
        for (int k = 0; k < 12; k++) addRun(1'b1, 0, 0, 0, 0, k % 4);
        // Into slot 2, then reset with EN high, then restart.
        for (int f = 0; f < 10; f++) addRun(1'b1, 3, 1, 3, 1, f);
        addVec(1'b1, 1'b1, 4'd3, 4'd1, 4'h0, 1'b0, 1'b0);
        addVec(1'b1, 1'b1, 4'd3, 4'd1, 4'h0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) addRun(1'b1, 3, 1, 3, 1, f);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst4 = vecs[i].rst; en4 = vecs[i].en; div4 = vecs[i].div; gap4 = vecs[i].gap;
            @(posedge clk);
            @(negedge clk);
            check("tbl", i, ph4, sync4, active4, vecs[i].ph, vecs[i].sync, vecs[i].active);
        end

        // Two-phase legacy instance has been held in reset so far.
        check("leg_rst", 0, {2'b00, ph2}, sync2, active2, 4'h0, 1'b0, 1'b0);

        // EN high from the first cycle out of reset: period 4.
        rst2 = 1'b0; en2 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("leg_run", k, {2'b00, ph2}, sync2, active2,
                  {2'b00, legacyPh(k % 4)}, (k % 4 == 0), 1'b1);
        end

        // Brief EN dip mid-frame must neither restart nor stop the sequence.
        for (int k = 12; k < 20; k++) begin
            en2 = (k == 13 || k == 14) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("leg_dip", k, {2'b00, ph2}, sync2, active2,
                  {2'b00, legacyPh(k % 4)}, (k % 4 == 0), 1'b1);
        end

        // Stop requested at frame cycle 1: PH[1] still completes, then idle.
        for (int k = 20; k < 26; k++) begin
            en2 = (k < 21) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (k < 24)
                check("leg_stop", k, {2'b00, ph2}, sync2, active2,
                      {2'b00, legacyPh(k % 4)}, (k % 4 == 0), 1'b1);
            else
                check("leg_stop", k, {2'b00, ph2}, sync2, active2, 4'h0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/multiphase_clock_gen.md
# multiphase_clock_gen

Parametrised successor to the two-phase non-overlapping clock generator. It derives PHASES non-overlapping phase strobes from the single system clock. Slot length and dead-time (gap) are programmable at run time, and the block adds a graceful-stop enable plus a frame-sync strobe. It sits between the core clock input and the phase-driven datapath and sequencer logic, replacing the fixed 4-cycle two-phase generator.

## Interface
- PHASES, default 2: number of phase outputs, legal range 2..8.
- CW, default 4: width of the slot-length and gap counters.
- CLK  in  1: system clock; all state changes on the rising edge.
- RST  in  1: synchronous, active-high reset.
- EN  in  1: run request. Rising edge while idle starts a frame; low requests a stop at the end of the current frame.
- DIV  in  CW: slot length minus 1, so a slot is DIV+1 CLK cycles.
- GAP  in  CW: dead cycles at the start of each slot, during which all phases are low.
- PH  out  PHASES: phase outputs, registered, at most one bit high in any cycle.
- SYNC  out  1: one-cycle strobe in the first cycle of every frame (slot 0, count 0). This is the O_S equivalent.
- ACTIVE  out  1: high while a frame is in progress.

## Operation
- States:
  - IDLE: counters held at 0, all outputs low.
  - RUN: frames repeat back to back.
  - DRAIN: EN has dropped and the current frame is finishing.
- Registers:
  - cnt (CW bits): cycle within the slot.
  - slot (ceil(log2 PHASES) bits): current phase slot.
  - div_s, gap_s: shadow copies of DIV and GAP.
- Shadow load: div_s and gap_s are loaded from DIV and GAP only on frame start (IDLE→RUN, and at each frame wrap in RUN). Changes to DIV or GAP mid-frame take effect at the next frame.
- Counting: cnt increments each cycle. When cnt==div_s, cnt goes to 0 and slot increments. When slot==PHASES-1 and cnt==div_s, the frame wraps (slot goes to 0).
- Output decode, evaluated per cycle against the registered state:
  - PH[k]=1 iff state≠IDLE, slot==k and cnt≥gap_s.
  - SYNC=1 iff state≠IDLE, slot==0 and cnt==0.
  - ACTIVE=1 iff state≠IDLE.
- Transitions:
  - IDLE→RUN when EN=1.
  - RUN→DRAIN when EN=0 and the frame is not at wrap.
  - RUN→IDLE when EN=0 at wrap.
  - RUN→RUN at wrap when EN=1.
  - DRAIN→IDLE at wrap.
  - DRAIN→RUN when EN returns to 1. No restart occurs; the frame continues.
- Gap rule: if gap_s>div_s, no PH bit ever rises. Counting and SYNC continue normally.
- DIV=0 with GAP=0: each phase is high for exactly 1 cycle and there is no dead time. This is legal.

## Timing
- Reset: state=IDLE, cnt=0, slot=0, div_s=0, gap_s=0, PH=0, SYNC=0, ACTIVE=0.
- All outputs come straight from flops. The implementation computes next-cycle decode from next-state, so outputs are glitch-free and carry no combinational path from inputs.
- Start latency: if EN is sampled high at edge t while idle, then from cycle t+1 SYNC=1, ACTIVE=1 and slot0/cnt0 is the current state.
- PH[0] first rises in cycle t+1+GAP.
- Frame period is PHASES·(DIV+1) cycles.
- Stop: the last PH pulse ends in the final cycle of slot PHASES-1. ACTIVE falls in the next cycle. A phase is never truncated.
- RST mid-frame: all outputs are low in the cycle after the reset edge. There is no drain.
- RST and EN high together: reset wins; the block starts on the first EN-high edge after RST falls.
- Non-overlap guarantee: at most one PH bit is high per cycle, including across the slot PHASES-1→0 wrap.

## Structure
- Package multiphase_clock_gen_pkg holds:
  - the state enum {IDLE, RUN, DRAIN};
  - MAX_PHASES=8;
  - the function slot_width(PHASES).
- Sub-module slot_counter (parameter CW): holds cnt, div_s and gap_s. It outputs slot_end (cnt==div_s) and in_window (cnt≥gap_s). The top level holds the FSM, the slot register and the output decode flops.

## Test plan
- Legacy equivalence. PHASES=2, DIV=1, GAP=1, EN held high from cycle 0 → period 4 cycles; PH[0] high in frame cycle 1, PH[1] high in frame cycle 3, SYNC in frame cycle 0, never both PH bits high.
- Wider config. PHASES=4, DIV=3, GAP=1 → 16-cycle frame; PH[k] high in frame cycles 4k+1..4k+3; SYNC at 0, 16, 32.
- Mid-frame reconfiguration. DIV changed 3→5 at frame cycle 6 → current frame keeps 4-cycle slots; the next frame, starting at SYNC, uses 6-cycle slots.
- Graceful stop. EN dropped in slot 1 of a 4-phase frame → PH[2] and PH[3] complete fully; ACTIVE falls 1 cycle after the last slot ends; PH stays 0 afterwards.
- Degenerate gap. GAP=5, DIV=3 → PH stays all-zero and SYNC pulses every PHASES·4 cycles. Separately, DIV=0, GAP=0 → each PH bit is a 1-cycle pulse in turn.
- Reset mid-operation. RST asserted in slot 2 with EN high → next cycle all outputs are 0. After RST releases with EN high, SYNC appears one cycle later.
